// File: rtl/mandel_pkg.sv
// mandel_pkg: shared fixed-point constants and iteration FSM state type
package mandel_pkg;

   localparam int FX_W    = 32;
   localparam int FX_FRAC = 21;

   localparam logic [FX_W-1:0] FX_ONE = 32'h0020_0000;
   localparam logic [FX_W-1:0] ESC_R2 = 32'h0080_0000;

   typedef enum logic [1:0] {IDLE, ITER, DONE} iter_state_t;

endpackage

// File: rtl/mandel_iter_ctrl.sv
// mandel_iter_ctrl: per-pixel iteration controller feeding and watching the diverge stage
module mandel_iter_ctrl
   import mandel_pkg::*;
#(
   parameter int MAX_ITER = 255,
   parameter int ITER_W   = 8,
   parameter int TAG_W    = 19
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FX_W-1:0]   in_a,
   input  logic [FX_W-1:0]   in_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic [FX_W-1:0]   c_a,
   output logic [FX_W-1:0]   c_b,
   output logic              ld,
   input  logic              diverged,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ITER_W-1:0] out_iter,
   output logic              out_escaped,
   output logic [TAG_W-1:0]  out_tag
);

   iter_state_t       state, state_n;
   logic [ITER_W-1:0] cnt;
   logic              accept;
   logic              hit_max;

   assign in_ready  = (state == IDLE) && !areset;
   assign out_valid = (state == DONE);
   assign ld        = (state != ITER);
   assign accept    = in_valid && in_ready;
   assign hit_max   = (cnt == ITER_W'(MAX_ITER));

   // state register
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state <= IDLE;
      else        state <= state_n;
   end

   // next-state: accept a point, iterate until escape or limit, hold result until taken
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = accept ? ITER : IDLE;
         ITER:    state_n = (diverged || hit_max) ? DONE : ITER;
         DONE:    state_n = out_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end

   // point capture, iteration counter and result registers
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         c_a         <= '0;
         c_b         <= '0;
         out_tag     <= '0;
         cnt         <= '0;
         out_iter    <= '0;
         out_escaped <= 1'b0;
      end else begin
         if (accept) begin
            c_a     <= in_a;
            c_b     <= in_b;
            out_tag <= in_tag;
            cnt     <= '0;
         end
         if (state == ITER) begin
            if (diverged) begin
               out_iter    <= cnt;
               out_escaped <= 1'b1;
            end else if (hit_max) begin
               out_iter    <= ITER_W'(MAX_ITER);
               out_escaped <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
// tb_mandel_iter_ctrl: directed bench with a behavioural diverge stage model
module tb_mandel_iter_ctrl;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [18:0] in_tag = '0;
   logic [31:0] c_a, c_b;
   logic        ld;
   logic        diverged;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_iter;
   logic        out_escaped;
   logic [18:0] out_tag;

   int total = 0;
   int passed = 0;

   mandel_iter_ctrl dut (
      .aclk(aclk), .areset(areset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .c_a(c_a), .c_b(c_b), .ld(ld), .diverged(diverged),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_iter(out_iter), .out_escaped(out_escaped), .out_tag(out_tag)
   );

   always #5 aclk = ~aclk;

   // diverge model: z <= z^2 + c in Q11.21, cleared by ld; escape when |z|^2 > 4.0
   logic signed [31:0] zr = '0, zi = '0;
   logic signed [63:0] rr, ii, ri, mag;
   always_comb begin
      rr = 64'($signed(zr)) * 64'($signed(zr));
      ii = 64'($signed(zi)) * 64'($signed(zi));
      ri = 64'($signed(zr)) * 64'($signed(zi));
      mag = (rr + ii) >>> 21;
      diverged = mag > 64'sh0080_0000;
   end
   always @(posedge aclk) begin
      if (ld) begin
         zr <= '0;
         zi <= '0;
      end else begin
         zr <= 32'((rr - ii) >>> 21) + $signed(c_a);
         zi <= 32'((ri <<< 1) >>> 21) + $signed(c_b);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [18:0] t);
      @(negedge aclk);
      chk("in_ready_before_accept", in_ready, 1);
      in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
      @(posedge aclk);
      #1 in_valid = 1'b0;
      chk("c_a_captured", c_a, a);
      chk("c_b_captured", c_b, b);
   endtask

   task automatic finish_point(input logic [31:0] a, input int eiter, input logic eesc, input logic [18:0] t);
      int n = 0;
      while (!out_valid && n < 400) begin
         @(posedge aclk);
         #1 n++;
         if (!out_valid) chk("c_a_stable_iter", c_a, a);
      end
      chk("latency", n, eiter + 1);
      chk("out_iter", out_iter, eiter);
      chk("out_escaped", out_escaped, eesc);
      chk("out_tag", out_tag, t);
      chk("ld_in_done", ld, 1);
   endtask

   task automatic drain;
      @(negedge aclk);
      out_ready = 1'b1;
      @(posedge aclk);
      #1 out_ready = 1'b0;
      chk("out_valid_cleared", out_valid, 0);
      chk("in_ready_after_handshake", in_ready, 1);
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [18:0] t, input int eiter, input logic eesc);
      offer(a, b, t);
      finish_point(a, eiter, eesc, t);
      drain();
   endtask

   initial begin
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ld", ld, 1);
      chk("rst_c_a", c_a, 0);
      chk("rst_out_iter", out_iter, 0);
      chk("rst_out_tag", out_tag, 0);
      @(negedge aclk);
      areset = 1'b0;
      #1 chk("in_ready_after_release", in_ready, 1);

      run(32'h0000_0000, 32'h0000_0000, 19'd11, 255, 1'b0);
      run(32'h0050_0000, 32'h0000_0000, 19'd22, 1, 1'b1);
      run(32'h0020_0000, 32'h0000_0000, 19'd33, 3, 1'b1);
      run(32'hFFC0_0000, 32'h0000_0000, 19'd44, 255, 1'b0);

      // backpressure: result held while a second point is offered
      offer(32'h0050_0000, 32'h0000_0000, 19'd55);
      finish_point(32'h0050_0000, 1, 1'b1, 19'd55);
      @(negedge aclk);
      in_a = 32'h0020_0000; in_b = '0; in_tag = 19'd66; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge aclk);
         #1;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_iter", out_iter, 1);
         chk("bp_out_tag", out_tag, 55);
         chk("bp_c_a", c_a, 32'h0050_0000);
      end
      @(negedge aclk);
      out_ready = 1'b1;
      @(posedge aclk);
      #1 out_ready = 1'b0;
      chk("bp_in_ready_after_td", in_ready, 1);
      chk("bp_c_a_not_yet", c_a, 32'h0050_0000);
      @(posedge aclk);
      #1 in_valid = 1'b0;
      chk("bp_second_accepted", c_a, 32'h0020_0000);
      finish_point(32'h0020_0000, 3, 1'b1, 19'd66);
      drain();

      // reset during ITER
      offer(32'h0000_0000, 32'h0000_0000, 19'd77);
      repeat (20) @(posedge aclk);
      #1 areset = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_ld", ld, 1);
      chk("midrst_in_ready", in_ready, 0);
      @(negedge aclk);
      areset = 1'b0;
      #1 chk("midrst_in_ready_release", in_ready, 1);
      run(32'h0050_0000, 32'h0000_0000, 19'd88, 1, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mandel_iter_ctrl.md
# mandel_iter_ctrl

Per-pixel iteration controller for the Mandelbrot datapath. It accepts one complex point c (Q11.21 real/imag plus a pixel tag) over a valid/ready handshake. It drives the `diverge` stage's `a`/`b`/`ld` inputs, counts iterations while watching `diverged`, and emits the escape count with a valid/ready handshake to the downstream colour/pixel writer. It feeds and consumes the `diverge` stage directly, one point at a time, with no overlap.

## Interface
- `MAX_ITER`, default 255: iteration limit. Must be ≤ 2^ITER_W − 1.
- `ITER_W`, default 8: width of the iteration count.
- `TAG_W`, default 19: width of the pixel tag (640×480 index).
- `aclk` in 1: the one clock; all state updates on its rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: point c is offered.
- `in_ready` out 1: block can accept a point.
- `in_a` in 32: Re(c), Q11.21 two's complement.
- `in_b` in 32: Im(c), Q11.21.
- `in_tag` in TAG_W: pixel tag.
- `c_a` out 32: registered Re(c), drives `diverge.a`.
- `c_b` out 32: registered Im(c), drives `diverge.b`.
- `ld` out 1: drives `diverge.ld`; 1 clears z to 0 at the next edge.
- `diverged` in 1: from `diverge`, combinational |z|² > 4.0 (0x00800000).
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts the result.
- `out_iter` out ITER_W: escape iteration count.
- `out_escaped` out 1: 1 if the point diverged; 0 if MAX_ITER was reached.
- `out_tag` out TAG_W: tag of the result.

## Operation
- FSM states are IDLE, ITER and DONE. Counter `cnt` is ITER_W bits wide.
- `in_ready` = (state==IDLE) and not `areset`. `out_valid` = (state==DONE). `ld` = (state != ITER).
- **IDLE:**
  - `ld`=1 holds z at 0.
  - On `in_valid && in_ready`: capture `in_a`, `in_b`, `in_tag` into `c_a`, `c_b`, tag; set `cnt`←0; go to ITER.
  - z is already 0 at this edge because `ld` was 1.
- **ITER:** `ld`=0, and `diverge` holds z_cnt. Evaluate in priority order:
  - If `diverged`: `out_iter`←`cnt`, `out_escaped`←1, go to DONE.
  - Else if `cnt`==MAX_ITER: `out_iter`←MAX_ITER, `out_escaped`←0, go to DONE.
  - Else: `cnt`←`cnt`+1.
- **DONE:**
  - `ld`=1 clears the datapath.
  - `out_iter`, `out_escaped`, `out_tag`, `c_a`, `c_b` are held stable.
  - On `out_ready`: go to IDLE.
- `diverged` is ignored outside ITER.
- The escape comparison is strict (> 4.0). This lives in `diverge`; the controller does not re-check it.
- z_0 = 0 never diverges, so the minimum escaped count is 1.
- `c_a`/`c_b` change only on acceptance and are stable throughout ITER.
- **Reset values:** state IDLE; `cnt`, `c_a`, `c_b`, `out_iter`, `out_escaped`, `out_tag` all 0; `out_valid` 0; `ld` 1; `in_ready` 0 while `areset` is high, 1 after release.
- **Reset mid-operation:** the in-flight point is dropped without output. `ld` goes to 1 immediately, so z clears at the first edge after release.

## Timing
- Accept edge is T0. ITER cycle k (k = 0, 1, …) observes z_k. Escape at z_n means `out_valid` rises at edge T0 + n + 1.
- Non-escaping point: `out_valid` at T0 + MAX_ITER + 1.
- `out_valid && out_ready` at edge Td: `in_ready` is 1 in the cycle after Td. Next accept is no earlier than Td + 1.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Structure
- Shared package `mandel_pkg` holds:
  - `FX_W`=32 and `FX_FRAC`=21.
  - `FX_ONE`=32'h00200000 and `ESC_R2`=32'h00800000.
  - The state enum `iter_state_t` (IDLE, ITER, DONE).
- Single module; counter and FSM inline. No sub-module is needed.
- `diverge` is instantiated beside this block in the parent `mandel_core`, not inside it.

## Test plan
- c=(0,0), default params → `out_iter`=255, `out_escaped`=0, `out_valid` 256 cycles after accept.
- c=(2.5,0): `in_a`=0x00500000 → `out_iter`=1, `out_escaped`=1, `out_valid` at T0+2.
- c=(1.0,0): `in_a`=0x00200000 → z goes 0, 1, 2, 5 with |z|²=4 not escaping → `out_iter`=3, `out_escaped`=1.
- c=(−2.0,0): `in_a`=0xFFC00000 → |z|²=4 exactly on every iteration → `out_iter`=255, `out_escaped`=0 (strict-compare boundary).
- Backpressure: `out_ready`=0 for 10 cycles after a result, with a second point offered meanwhile.
  - Outputs stay stable; `in_ready`=0; the second point is not accepted.
  - Second point is accepted one cycle after the handshake and gives the correct result.
- Assert `areset` during ITER of c=(0,0):
  - `out_valid`=0 and `ld`=1 immediately.
  - After release, `in_ready`=1; c=(2.5,0) then yields `out_iter`=1.
